// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core: FSM state encoding,
// parity mode constants and a constant-function log2 used for counter widths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: full or half-period load, auto-reloads on each tick
// while enabled so consecutive bits stay exactly CLK_DIV cycles apart.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    input  logic half_load,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = FULL;
        end else if (half_load) begin
            cnt_d = HALF;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? FULL : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART engine with sticky frame/parity/overrun flags.
// Define UART_RX_FIFO_EN to replace the RX holding register with a FWFT FIFO.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              uart_tx,
    input  logic              uart_rx,
    input  logic [DATA_W-1:0] data_tx,
    output logic [DATA_W-1:0] data_rx,
    output logic              uart_valid,
    input  logic              uart_ready,
    output logic              uart_busy,
    input  logic              uart_begin,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err,
    input  logic              err_clr
);

    localparam int IDX_W = clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

`ifndef SYNTHESIS
    initial begin
        if (CLK_DIV < 4) $error("uart_core_param: CLK_DIV must be >= 4");
        if (DATA_W < 5 || DATA_W > 9) $error("uart_core_param: DATA_W must be 5..9");
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) $error("uart_core_param: PARITY must be 0..2");
        if (STOP_BITS != 1 && STOP_BITS != 2) $error("uart_core_param: STOP_BITS must be 1 or 2");
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
            $error("uart_core_param: FIFO_DEPTH must be a power of 2 >= 2");
    end
`endif

    function automatic logic par_of(input logic [DATA_W-1:0] d);
        return (PARITY == PAR_EVEN) ? ^d : ~^d;
    endfunction

    uart_state_e       tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              tx_load, tx_tick, tx_timer_en;

    uart_state_e       rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic              rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d;
    logic              rx_half_load, rx_tick, rx_timer_en, rx_done;
    logic              set_fe, set_pe, set_ov;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_err_q, overrun_err_d;

    assign tx_timer_en = (tx_state_q != ST_IDLE);
    assign rx_timer_en = (rx_state_q != ST_IDLE);

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (tx_timer_en),
        .load      (tx_load),
        .half_load (1'b0),
        .tick      (tx_tick)
    );

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (rx_timer_en),
        .load      (1'b0),
        .half_load (rx_half_load),
        .tick      (rx_tick)
    );

    // The line level is decoded from the next state so uart_tx comes straight off a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (uart_begin) begin
                    tx_state_d = ST_START;
                    tx_shift_d = data_tx;
                    tx_par_d   = par_of(data_tx);
                    tx_load    = 1'b1;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_state_d = ST_DATA;
                    tx_idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == LAST_DATA) begin
                        tx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                        tx_idx_d   = '0;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tx_tick) tx_state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tx_tick) begin
                    if (tx_idx_q == LAST_STOP) tx_state_d = ST_IDLE;
                    else tx_idx_d = tx_idx_q + 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        busy_d = (tx_state_d != ST_IDLE);
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_shift_d[0];
            ST_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // Sampling points sit mid-bit; after the stop sample we are back in IDLE half a bit early.
    always_comb begin
        rx_sync1_d   = uart_rx;
        rx_sync2_d   = rx_sync1_q;
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_idx_d     = rx_idx_q;
        rx_half_load = 1'b0;
        rx_done      = 1'b0;
        set_fe       = 1'b0;
        set_pe       = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_sync2_q) begin
                    rx_state_d   = ST_START;
                    rx_half_load = 1'b1;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (rx_sync2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_idx_q == LAST_DATA) begin
                        rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_tick) begin
                    set_pe     = (rx_sync2_q != par_of(rx_shift_q));
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_tick) begin
                    set_fe     = !rx_sync2_q;
                    rx_done    = 1'b1;
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              fifo_empty, fifo_full, fifo_push, fifo_pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_pop   = !fifo_empty && uart_ready;
        fifo_push  = rx_done && (!fifo_full || fifo_pop);
        set_ov     = rx_done && fifo_full && !fifo_pop;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign data_rx    = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign uart_valid = !fifo_empty;
`else
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_valid_q, hold_valid_d;

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        set_ov       = 1'b0;
        if (hold_valid_q && uart_ready) begin
            hold_valid_d = 1'b0;
        end
        if (rx_done) begin
            if (!hold_valid_q || uart_ready) begin
                hold_data_d  = rx_shift_q;
                hold_valid_d = 1'b1;
            end else begin
                set_ov = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign data_rx    = hold_data_q;
    assign uart_valid = hold_valid_q;
`endif

    // Set beats clear when both land in the same cycle.
    always_comb begin
        frame_err_d   = err_clr ? 1'b0 : frame_err_q;
        parity_err_d  = err_clr ? 1'b0 : parity_err_q;
        overrun_err_d = err_clr ? 1'b0 : overrun_err_q;
        if (set_fe) frame_err_d = 1'b1;
        if (set_pe) parity_err_d = 1'b1;
        if (set_ov) overrun_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q    <= ST_IDLE;
            tx_shift_q    <= '0;
            tx_idx_q      <= '0;
            tx_par_q      <= 1'b0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            rx_sync1_q    <= 1'b1;
            rx_sync2_q    <= 1'b1;
            rx_state_q    <= ST_IDLE;
            rx_shift_q    <= '0;
            rx_idx_q      <= '0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            tx_idx_q      <= tx_idx_d;
            tx_par_q      <= tx_par_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            rx_sync1_q    <= rx_sync1_d;
            rx_sync2_q    <= rx_sync2_d;
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_idx_q      <= rx_idx_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign uart_tx     = tx_q;
    assign uart_busy   = busy_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: an 8N1 instance for TX waveforms and
// reset abort, and an even-parity instance for loopback, RX errors and overrun.
module tb_uart_core_param;

    localparam int DIV = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, n1_rst_n;
    logic       loop_en, rx_drv;

    logic       m_tx, m_rx, m_busy, m_begin, m_valid, m_ready, m_fe, m_pe, m_ov, m_clr;
    logic [7:0] m_dtx, m_drx;

    logic       n1_tx, n1_busy, n1_begin, n1_valid, n1_fe, n1_pe, n1_ov;
    logic [7:0] n1_dtx, n1_drx;

    assign m_rx = loop_en ? m_tx : rx_drv;

    uart_core_param #(
        .CLK_DIV(DIV), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .uart_tx(m_tx), .uart_rx(m_rx),
        .data_tx(m_dtx), .data_rx(m_drx), .uart_valid(m_valid), .uart_ready(m_ready),
        .uart_busy(m_busy), .uart_begin(m_begin), .frame_err(m_fe), .parity_err(m_pe),
        .overrun_err(m_ov), .err_clr(m_clr)
    );

    uart_core_param #(
        .CLK_DIV(DIV), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_n1 (
        .clk(clk), .rst_n(n1_rst_n), .uart_tx(n1_tx), .uart_rx(1'b1),
        .data_tx(n1_dtx), .data_rx(n1_drx), .uart_valid(n1_valid), .uart_ready(1'b1),
        .uart_busy(n1_busy), .uart_begin(n1_begin), .frame_err(n1_fe), .parity_err(n1_pe),
        .overrun_err(n1_ov), .err_clr(1'b0)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int valid_cycles = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_ok;
        logic       stop_ok;
        logic       exp_fe;
        logic       exp_pe;
    } rx_vec_t;

    rx_vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every byte the consumer accepts must match the oldest expected byte.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) checkOutput("rx byte with empty scoreboard", exp_q.size(), 1);
                else checkOutput("rx data", m_drx, exp_q.pop_front());
            end
        end
    end

    task automatic driveBit(input logic b);
        rx_drv = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic par_ok, input logic stop_ok);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
        driveBit((^d) ^ !par_ok);
        driveBit(stop_ok);
        rx_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drained", exp_q.size(), 0);
    endtask

    task automatic waitBusyLow(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx busy timeout", m_busy, 0);
    endtask

    task automatic clearErrors();
        @(negedge clk);
        m_clr = 1'b1;
        @(negedge clk);
        m_clr = 1'b0;
        checkOutput("frame_err after clear", m_fe, 0);
        checkOutput("parity_err after clear", m_pe, 0);
        checkOutput("overrun_err after clear", m_ov, 0);
    endtask

    // Start bit, 8 data bits LSB first, stop bit; busy must cover exactly 80 cycles.
    task automatic checkTxFrame(input logic [7:0] d);
        logic [9:0] bits;
        int bad_tx, bad_busy;
        bits = {1'b1, d, 1'b0};
        bad_busy = 0;
        @(negedge clk);
        n1_dtx = d;
        n1_begin = 1'b1;
        @(negedge clk);
        n1_begin = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bad_tx = 0;
            for (int c = 0; c < DIV; c++) begin
                if (n1_tx !== bits[b]) bad_tx++;
                if (n1_busy !== 1'b1) bad_busy++;
                @(negedge clk);
            end
            checkOutput($sformatf("tx bit %0d of 0x%02h wrong cycles", b, d), bad_tx, 0);
        end
        checkOutput($sformatf("busy low cycles in frame 0x%02h", d), bad_busy, 0);
        checkOutput("busy after frame", n1_busy, 0);
        checkOutput("tx idle after frame", n1_tx, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; n1_rst_n = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        m_begin = 1'b0; m_dtx = 8'h00; m_ready = 1'b1; m_clr = 1'b0;
        n1_begin = 1'b0; n1_dtx = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset uart_tx", m_tx, 1);
        checkOutput("reset uart_busy", m_busy, 0);
        checkOutput("reset uart_valid", m_valid, 0);
        checkOutput("reset data_rx", m_drx, 0);
        checkOutput("reset error flags", {m_fe, m_pe, m_ov}, 0);
        checkOutput("reset n1 tx/busy", {n1_tx, n1_busy}, 2'b10);
        checkOutput("reset n1 valid/data", {n1_valid, n1_drx}, 0);
        rst_n = 1'b1; n1_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] TX waveform, 8N1");
        checkTxFrame(8'hA5);
        checkTxFrame(8'h3C);

        $display("[TB] Reset during TX bit 3");
        @(negedge clk);
        n1_dtx = 8'hA5; n1_begin = 1'b1;
        @(negedge clk);
        n1_begin = 1'b0;
        repeat (35) @(negedge clk);
        checkOutput("tx in bit 3 before reset", {n1_busy, n1_tx}, 2'b10);
        n1_rst_n = 1'b0;
        @(negedge clk);
        checkOutput("tx after mid-frame reset", n1_tx, 1);
        checkOutput("busy after mid-frame reset", n1_busy, 0);
        n1_rst_n = 1'b1;
        checkTxFrame(8'h0F);

        $display("[TB] TX->RX loopback, even parity");
        loop_en = 1'b1;
        foreach (vecs[i]) begin
            if (i < 3) begin
                @(negedge clk);
                m_dtx = (i == 0) ? 8'h3C : vecs[i].data;
                m_begin = 1'b1;
                exp_q.push_back(m_dtx);
                valid_cycles = 0;
                @(negedge clk);
                m_begin = 1'b0;
                if (i == 0) begin
                    repeat (20) @(negedge clk);
                    m_dtx = 8'h99; m_begin = 1'b1;
                    @(negedge clk);
                    m_begin = 1'b0;
                end
                waitBusyLow(200);
                repeat (10) @(negedge clk);
                waitDrain(100);
                checkOutput("valid pulse width", valid_cycles, 1);
                checkOutput("loopback error flags", {m_fe, m_pe, m_ov}, 0);
            end
        end
        loop_en = 1'b0;

        $display("[TB] RX error table");
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vecs[i].data);
            applyStimulus(vecs[i].data, vecs[i].par_ok, vecs[i].stop_ok);
            waitDrain(100);
            checkOutput($sformatf("frame_err vec %0d", i), m_fe, vecs[i].exp_fe);
            checkOutput($sformatf("parity_err vec %0d", i), m_pe, vecs[i].exp_pe);
            checkOutput($sformatf("overrun_err vec %0d", i), m_ov, 0);
            clearErrors();
        end

        $display("[TB] RX glitch rejection");
        valid_cycles = 0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("valid after glitch", valid_cycles, 0);
        checkOutput("flags after glitch", {m_fe, m_pe, m_ov}, 0);
        exp_q.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        waitDrain(100);

        $display("[TB] RX overrun");
        m_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'(8'h11 * (i + 1));
            if (i < 4) exp_q.push_back(d);
            applyStimulus(d, 1'b1, 1'b1);
        end
`else
        exp_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b1);
`endif
        checkOutput("held data_rx on overrun", m_drx, 8'h11);
        checkOutput("valid held on overrun", m_valid, 1);
        checkOutput("overrun_err set", m_ov, 1);
        checkOutput("no frame/parity on overrun", {m_fe, m_pe}, 0);
        @(negedge clk);
        m_ready = 1'b1;
        waitDrain(50);
        @(negedge clk);
        checkOutput("valid after draining", m_valid, 0);
        clearErrors();

        checkOutput("n1 rx flags idle", {n1_valid, n1_fe, n1_pe, n1_ov}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART engine, the next generation of the fixed 8N1 front end. It provides configurable bit timing, data width, parity and stop bits, plus frame, parity and overrun error reporting. It sits between the board pins and the picture-frame controller's byte-level command/data path. TX and RX run independently off one clock.

Parameters:
CLK_DIV, 868, clk cycles per bit (50 MHz / 57600 baud); legal >= 4
DATA_W, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2; RX checks only the first stop bit
FIFO_DEPTH, 4, RX FIFO entries (power of 2); used only with UART_RX_FIFO_EN

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
uart_tx  out  1  serial out, idle high
uart_rx  in  1  serial in, asynchronous
data_tx  in  DATA_W  byte to send, sampled on accepted uart_begin
data_rx  out  DATA_W  received byte, valid while uart_valid
uart_valid  out  1  data_rx holds an unconsumed byte
uart_ready  in  1  consumer accepts data_rx when uart_valid && uart_ready
uart_busy  out  1  TX frame in progress
uart_begin  in  1  start TX; accepted only when !uart_busy
frame_err  out  1  sticky: RX stop bit sampled low
parity_err  out  1  sticky: RX parity mismatch
overrun_err  out  1  sticky: RX byte dropped
err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset (rst_n low at a clk edge): uart_tx=1, uart_busy=0, uart_valid=0, data_rx=0, all error flags 0, both FSMs to IDLE, counters 0. Reset mid-frame aborts the frame immediately, with no partial output.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - uart_begin && !uart_busy latches data_tx.
  - uart_busy=1 and uart_tx=0 from the next cycle.
  - Each bit lasts exactly CLK_DIV cycles. Data is sent LSB first.
  - Parity bit = ^data (even) or ~^data (odd).
  - STOP holds uart_tx=1 for STOP_BITS*CLK_DIV cycles. uart_busy falls on the cycle after the last stop cycle.
  - Total busy time = (1 + DATA_W + (PARITY!=0) + STOP_BITS)*CLK_DIV cycles.
  - uart_begin while busy is ignored, with no queuing.
  - Begin in the same cycle busy falls is accepted; back-to-back frames have no idle gap.
- RX path: uart_rx passes through a 2-flop synchroniser, so latency from pin to FSM is 2 cycles.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: a synced low level starts the bit counter.
  - START: at CLK_DIV/2 the line is resampled. If high, it is a glitch; return to IDLE with no error.
  - Remaining bits are sampled every CLK_DIV cycles from the mid-start point.
  - STOP sample low sets frame_err; the byte is still delivered.
  - Parity mismatch sets parity_err; the byte is still delivered.
  - After the stop sample, return to IDLE immediately (half-bit early) to tolerate clock skew.
- RX handshake:
  - uart_valid rises the cycle after the stop sample.
  - data_rx and uart_valid hold stable until uart_valid && uart_ready. uart_valid falls the next cycle.
  - If a new byte completes while uart_valid=1 and not accepted that cycle, the new byte is dropped, overrun_err is set and the held byte is unchanged.
  - Completion in the same cycle as acceptance is not an overrun; the new byte is presented next cycle.
- Error flags: err_clr clears all three. If a flag's set condition and err_clr coincide, set wins.
- Parameter checks: illegal parameter values trigger a $error in an initial block (simulation only).

Optional Feature:
UART_RX_FIFO_EN:
- Defined: a FIFO_DEPTH-entry RX FIFO sits between the RX FSM and data_rx/uart_valid, in first-word-fall-through form (uart_valid = !empty).
  - Overrun only when the FIFO is full at byte completion.
  - A simultaneous push and pop while full is allowed and is not an overrun.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- Undefined: single holding register as described above; FIFO_DEPTH is ignored.

Decomposition:
- Package uart_pkg holds:
  - TX/RX state enums (IDLE, START, DATA, PARITY, STOP)
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - function clog2 for counter widths: bit counter $clog2(CLK_DIV), data index $clog2(DATA_W+1)
- One natural sub-module, uart_bit_timer: a CLK_DIV down-counter with load/half-load and a tick output, instantiated once for TX and once for RX.

Test Plan:
1. CLK_DIV=8, 8N1, send 0xA5 -> uart_tx low 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high. uart_busy high exactly 80 cycles.
2. TX loopback to RX, PARITY=2, send 0x3C, uart_ready=1 -> uart_valid pulses 1 cycle with data_rx=0x3C. No errors.
3. Drive RX frame 0x55 with stop bit low -> uart_valid with data_rx=0x55 and frame_err=1. err_clr pulse -> frame_err=0.
4. uart_ready=0, receive 0x11 then 0x22 -> data_rx stays 0x11 and overrun_err=1. With UART_RX_FIFO_EN and depth 4, five bytes -> first four read in order, overrun on the fifth.
5. Low glitch of 3 cycles on uart_rx (CLK_DIV=8) -> no uart_valid, no errors, RX back in IDLE.
6. rst_n low mid-TX frame at bit 3 for 1 cycle -> next cycle uart_tx=1 and uart_busy=0. Then uart_begin with 0x0F -> full frame sent.
